fsm_traffic_param: RTL and testbench

FSM_TRAFFIC_PARAM -- requirements
Module: fsm_traffic_param

---
 rtl/fsm_traffic_param.sv | 163 ++++++++++++++++
 tb/tb_fsm_traffic_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_traffic_param.sv
// Two-road traffic light controller with pedestrian walk phase, side-road sensor
// extension and a flashing night/fault mode. All outputs are registered.
module fsm_traffic_param #(
  parameter int TICK_DIV = 4,
  parameter int G_T      = 6,
  parameter int SIDE_T   = 3,
  parameter int EXT_T    = 3,
  parameter int Y_T      = 2,
  parameter int W_T      = 3,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       walk,
  input  logic       sensor,
  input  logic       flash,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MAIN_G = 3'd0,
    S_MAIN_Y = 3'd1,
    S_WALK   = 3'd2,
    S_SIDE_G = 3'd3,
    S_SIDE_Y = 3'd4,
    S_FLASH  = 3'd5
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(G_T - 1);
  localparam logic [CNT_W-1:0] S_LOAD    = CNT_W'(SIDE_T - 1);
  localparam logic [CNT_W-1:0] Y_LOAD    = CNT_W'(Y_T - 1);
  localparam logic [CNT_W-1:0] W_LOAD    = CNT_W'(W_T - 1);
  localparam logic [CNT_W-1:0] E_LOAD    = CNT_W'((EXT_T > 0) ? EXT_T - 1 : 0);
  localparam logic             EXT_EN    = (EXT_T > 0);

  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      S_MAIN_G: load_for = G_LOAD;
      S_MAIN_Y: load_for = Y_LOAD;
      S_WALK:   load_for = W_LOAD;
      S_SIDE_G: load_for = S_LOAD;
      S_SIDE_Y: load_for = Y_LOAD;
      default:  load_for = G_LOAD;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s, input logic want_walk);
    case (s)
      S_MAIN_G: next_phase = S_MAIN_Y;
      S_MAIN_Y: next_phase = want_walk ? S_WALK : S_SIDE_G;
      S_WALK:   next_phase = S_SIDE_G;
      S_SIDE_G: next_phase = S_SIDE_Y;
      S_SIDE_Y: next_phase = S_MAIN_G;
      default:  next_phase = S_MAIN_G;
    endcase
  endfunction

  // Main road is red whenever the side road or pedestrians may move.
  function automatic logic [2:0] main_of(input state_t s, input logic b);
    case (s)
      S_MAIN_G: main_of = 3'b001;
      S_MAIN_Y: main_of = 3'b010;
      S_FLASH:  main_of = b ? 3'b010 : 3'b000;
      default:  main_of = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] side_of(input state_t s, input logic b);
    case (s)
      S_SIDE_G: side_of = 3'b001;
      S_SIDE_Y: side_of = 3'b010;
      S_FLASH:  side_of = b ? 3'b100 : 3'b000;
      default:  side_of = 3'b100;
    endcase
  endfunction

  state_t            state_r, state_s;
  logic [TW-1:0]     tick_cnt_r, tick_cnt_s;
  logic [CNT_W-1:0]  timer_r, timer_s;
  logic              walk_req_r, walk_req_s;
  logic              ext_r, ext_s;
  logic              blink_r, blink_s;
  logic              tick_s, phase_end_s, may_extend_s, clear_req_s;

  // Next-state, timer, tick and request bookkeeping.
  always_comb begin
    tick_s       = (tick_cnt_r == TICK_LAST);
    phase_end_s  = tick_s && (timer_r == '0);
    may_extend_s = sensor && !ext_r && EXT_EN &&
                   ((state_r == S_MAIN_G) || (state_r == S_SIDE_G));
    state_s      = state_r;
    timer_s      = timer_r;
    ext_s        = ext_r;
    blink_s      = blink_r;
    tick_cnt_s   = tick_s ? '0 : tick_cnt_r + TW'(1);
    if (flash) begin
      if (state_r != S_FLASH) begin
        state_s = S_FLASH;
        blink_s = 1'b1;
        ext_s   = 1'b0;
      end else if (tick_s) begin
        blink_s = ~blink_r;
      end else begin
        blink_s = blink_r;
      end
    end else if (state_r == S_FLASH) begin
      state_s    = S_MAIN_G;
      tick_cnt_s = '0;
      timer_s    = G_LOAD;
      ext_s      = 1'b0;
    end else if (phase_end_s) begin
      if (may_extend_s) begin
        timer_s = E_LOAD;
        ext_s   = 1'b1;
      end else begin
        state_s = next_phase(state_r, walk_req_r || walk);
        timer_s = load_for(next_phase(state_r, walk_req_r || walk));
        ext_s   = 1'b0;
      end
    end else if (tick_s) begin
      timer_s = timer_r - CNT_W'(1);
    end else begin
      timer_s = timer_r;
    end
    // A request is consumed by entering WALK and discarded by entering FLASH.
    clear_req_s = ((state_s == S_WALK) && (state_r != S_WALK)) ||
                  ((state_s == S_FLASH) && (state_r != S_FLASH));
    walk_req_s  = clear_req_s ? 1'b0 : (walk_req_r || (walk && (state_r != S_WALK)));
  end

  // State, timers and registered light outputs.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_r    <= S_MAIN_G;
      tick_cnt_r <= '0;
      timer_r    <= G_LOAD;
      walk_req_r <= 1'b0;
      ext_r      <= 1'b0;
      blink_r    <= 1'b1;
      main_light <= 3'b001;
      side_light <= 3'b100;
      walk_light <= 1'b0;
      phase      <= 3'd0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      timer_r    <= timer_s;
      walk_req_r <= walk_req_s;
      ext_r      <= ext_s;
      blink_r    <= blink_s;
      main_light <= main_of(state_s, blink_s);
      side_light <= side_of(state_s, blink_s);
      walk_light <= (state_s == S_WALK);
      phase      <= state_s;
    end
  end

endmodule

// File: tb/tb_fsm_traffic_param.sv
// Drives a default-parameter instance and a TICK_DIV=1/G_T=1/EXT_T=0 instance with
// shared stimulus and compares both against a clock-counting reference model.
module tb_fsm_traffic_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, walk, sensor, flash;
  logic [2:0] mo [2];
  logic [2:0] so [2];
  logic [2:0] po [2];
  logic       wo [2];

  int total = 0;
  int bad   = 0;

  fsm_traffic_param dut0 (
    .clock(clock), .rst(rst), .walk(walk), .sensor(sensor), .flash(flash),
    .main_light(mo[0]), .side_light(so[0]), .walk_light(wo[0]), .phase(po[0])
  );

  fsm_traffic_param #(.TICK_DIV(1), .G_T(1), .EXT_T(0)) dut1 (
    .clock(clock), .rst(rst), .walk(walk), .sensor(sensor), .flash(flash),
    .main_light(mo[1]), .side_light(so[1]), .walk_light(wo[1]), .phase(po[1])
  );

  // Configuration per instance; durations indexed by phase code 0..4
  // (main green, main yellow, walk, side green, side yellow).
  int tdiv_c [2]    = '{4, 1};
  int ext_c  [2]    = '{3, 0};
  int dur_c  [2][5] = '{'{6, 2, 3, 3, 2}, '{1, 2, 3, 3, 2}};
  logic [2:0] main_tab [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

  // Model: current phase, clocks left in it (including the current one), and
  // position within the tick period (only needed for blinking).
  int m_ph   [2];
  int m_rem  [2];
  int m_tpos [2];
  bit m_ext  [2];
  bit m_wreq [2];
  bit m_blnk [2];

  task automatic model_step(input int d);
    bit tick;
    bit wnext;
    int nxt;
    tick = (m_tpos[d] == tdiv_c[d] - 1);
    if (!rst) begin
      m_ph[d] = 0; m_rem[d] = dur_c[d][0] * tdiv_c[d]; m_tpos[d] = 0;
      m_ext[d] = 0; m_wreq[d] = 0; m_blnk[d] = 1;
    end else begin
      wnext = m_wreq[d] || (walk && m_ph[d] != 2);
      if (flash) begin
        if (m_ph[d] != 5) begin
          m_ph[d] = 5; m_blnk[d] = 1; m_ext[d] = 0; wnext = 0;
        end else if (tick) begin
          m_blnk[d] = !m_blnk[d];
        end
        m_tpos[d] = tick ? 0 : m_tpos[d] + 1;
      end else if (m_ph[d] == 5) begin
        m_ph[d] = 0; m_rem[d] = dur_c[d][0] * tdiv_c[d]; m_ext[d] = 0; m_tpos[d] = 0;
      end else begin
        if (m_rem[d] == 1) begin
          if ((m_ph[d] == 0 || m_ph[d] == 3) && sensor && !m_ext[d] && ext_c[d] > 0) begin
            m_rem[d] = ext_c[d] * tdiv_c[d]; m_ext[d] = 1;
          end else begin
            case (m_ph[d])
              0: nxt = 1;
              1: nxt = (m_wreq[d] || walk) ? 2 : 3;
              2: nxt = 3;
              3: nxt = 4;
              default: nxt = 0;
            endcase
            m_ph[d] = nxt; m_rem[d] = dur_c[d][nxt] * tdiv_c[d]; m_ext[d] = 0;
            if (nxt == 2) wnext = 0;
          end
        end else begin
          m_rem[d] = m_rem[d] - 1;
        end
        m_tpos[d] = tick ? 0 : m_tpos[d] + 1;
      end
      m_wreq[d] = wnext;
    end
  endtask

  task automatic check(input int d);
    logic [2:0] em, es, ep;
    logic       ew;
    if (m_ph[d] == 5) begin
      em = m_blnk[d] ? 3'b010 : 3'b000;
      es = m_blnk[d] ? 3'b100 : 3'b000;
    end else begin
      em = main_tab[m_ph[d]];
      es = side_tab[m_ph[d]];
    end
    ew = (m_ph[d] == 2);
    ep = 3'(m_ph[d]);
    total++;
    assert (mo[d] === em) else begin
      bad++; $error("FAIL main_light dut%0d t=%0t got=%b exp=%b", d, $time, mo[d], em);
    end
    total++;
    assert (so[d] === es) else begin
      bad++; $error("FAIL side_light dut%0d t=%0t got=%b exp=%b", d, $time, so[d], es);
    end
    total++;
    assert (wo[d] === ew) else begin
      bad++; $error("FAIL walk_light dut%0d t=%0t got=%b exp=%b", d, $time, wo[d], ew);
    end
    total++;
    assert (po[d] === ep) else begin
      bad++; $error("FAIL phase dut%0d t=%0t got=%0d exp=%0d", d, $time, po[d], ep);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    check(0);
    check(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_phase0(input logic [2:0] code, input int limit);
    int i;
    i = 0;
    while (i < limit && po[0] !== code) begin
      cycle();
      i++;
    end
    total++;
    assert (po[0] === code) else begin
      bad++; $error("FAIL wait_phase timeout got=%0d exp=%0d", po[0], code);
    end
  endtask

  int  n0, n1;
  bit  d0, d1;

  initial begin
    rst = 1'b0; walk = 1'b0; sensor = 1'b0; flash = 1'b0;
    #2;
    run(2);
    rst = 1'b1;

    // Idle cycle: measure the first main-green stretch of both instances.
    n0 = 1; n1 = 1; d0 = 0; d1 = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!d0) begin
        if (mo[0] === 3'b001) n0++;
        else d0 = 1;
      end
      if (!d1) begin
        if (mo[1] === 3'b001) n1++;
        else d1 = 1;
      end
    end
    total++;
    assert (n0 == 24) else begin
      bad++; $error("FAIL main_g_len_default got=%0d exp=%0d", n0, 24);
    end
    total++;
    assert (n1 == 1) else begin
      bad++; $error("FAIL main_g_len_boundary got=%0d exp=%0d", n1, 1);
    end
    run(40);

    // Walk pulse during main green, then two full rounds.
    wait_phase0(3'd0, 100);
    run(3);
    walk = 1'b1; cycle(); walk = 1'b0;
    run(120);

    // Sensor held high.
    sensor = 1'b1;
    run(150);
    sensor = 1'b0;

    // Flash raised mid side-green, then lowered.
    wait_phase0(3'd3, 200);
    run(5);
    walk = 1'b1; cycle(); walk = 1'b0;
    flash = 1'b1; run(21);
    flash = 1'b0; run(40);

    // Reset in the middle of a walk phase.
    wait_phase0(3'd0, 200);
    walk = 1'b1; cycle(); walk = 1'b0;
    wait_phase0(3'd2, 200);
    run(3);
    rst = 1'b0; cycle(); rst = 1'b1;
    run(70);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 599) != 0);
      walk = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) sensor = ~sensor;
      if ($urandom_range(0, 89) == 0) flash = ~flash;
      cycle();
    end
    rst = 1'b1; walk = 1'b0; sensor = 1'b0; flash = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
